rr_mux_arbiter8: RTL and testbench

Round-robin arbiter and sequencer for the shared 8:1, 4-bit select mux. Eight requesters compete for a single 4-bit output lane. The block owns the 3-bit select code, issues one-hot grants, and registers the selected data. A per-grant hold limit lets an owner stream several words while still bounding latency for the other requesters.

---
 rtl/rr_mux_arbiter8.sv | 128 ++++++++++++
 tb/tb_rr_mux_arbiter8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter8.sv
// Round-robin arbiter and sequencer for a shared 8:1, 4-bit select mux.
// Eight requesters compete for one 4-bit output lane. The owner may stream
// up to MAX_HOLD words while others wait, after which the grant rotates.
// An uncontended owner keeps the grant for as long as it requests.
module rr_mux_arbiter8 #(
   parameter int MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  req,
   input  logic [31:0] inp,
   output logic [7:0]  gnt,
   output logic [2:0]  sel,
   output logic [3:0]  out,
   output logic        out_valid,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   state_t     state;
   logic [2:0] ptr;
   logic [2:0] owner;
   logic [3:0] hold_cnt;

   logic       own_req;
   logic [7:0] others;
   logic [7:0] arb_req;
   logic [3:0] hold_next;
   logic       switch_owner;
   logic       win_found;
   logic [2:0] win_idx;

   // First requester at or after start, wrapping 7 -> 0; result is {found, index}.
   function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] start);
      logic       found;
      logic [2:0] idx;
      logic [2:0] cand;
      found = 1'b0;
      idx   = start;
      for (int i = 0; i < 8; i++) begin
         cand = start + 3'(i);
         if (!found && r[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // Next-state decisions: transfer detection, saturating hold count, arbitration.
   // ptr always equals owner+1 while granting, so one scan start serves both states.
   always_comb begin
      own_req   = req[owner];
      others    = req & ~(8'(1) << owner);
      hold_next = hold_cnt;
      if (own_req) begin
         hold_next = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;
      end
      arb_req = (state == IDLE) ? req : others;
      {win_found, win_idx} = arbitrate(arb_req, ptr);
      switch_owner = (state == GRANT) &&
                     (!own_req || ((hold_next == HOLD_MAX) && (others != 8'd0)));
   end

   // Sequencer FSM with registered grant, select and data outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         owner     <= 3'd0;
         hold_cnt  <= 4'd0;
         gnt       <= 8'd0;
         sel       <= 3'd0;
         out       <= 4'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (win_found) begin
                  state    <= GRANT;
                  owner    <= win_idx;
                  ptr      <= win_idx + 3'd1;
                  hold_cnt <= 4'd0;
                  gnt      <= 8'(1) << win_idx;
                  sel      <= win_idx;
                  busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (own_req) begin
                  out       <= inp[{owner, 2'b00} +: 4];
                  out_valid <= 1'b1;
                  hold_cnt  <= hold_next;
               end else begin
                  out_valid <= 1'b0;
               end
               if (switch_owner) begin
                  if (win_found) begin
                     owner    <= win_idx;
                     ptr      <= win_idx + 3'd1;
                     hold_cnt <= 4'd0;
                     gnt      <= 8'(1) << win_idx;
                     sel      <= win_idx;
                  end else begin
                     state <= IDLE;
                     gnt   <= 8'd0;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 8'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter8.sv
// Testbench for rr_mux_arbiter8: table-driven vectors on a MAX_HOLD=4 instance
// plus hand-written sequences for hold, reset and full rotation with MAX_HOLD=1.
module tb_rr_mux_arbiter8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic [31:0] inp;

   logic [7:0]  gnt0, gnt1;
   logic [2:0]  sel0, sel1;
   logic [3:0]  out0, out1;
   logic        ov0, ov1;
   logic        busy0, busy1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  req;
      logic [31:0] inp;
      logic [7:0]  gnt;
      logic [2:0]  sel;
      logic        chk_sel;
      logic [3:0]  out;
      logic        ov;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   rr_mux_arbiter8 #(.MAX_HOLD(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .inp(inp),
      .gnt(gnt0), .sel(sel0), .out(out0), .out_valid(ov0), .busy(busy0)
   );

   rr_mux_arbiter8 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .inp(inp),
      .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(ov1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] r, input logic [31:0] d, input logic [7:0] g,
                      input logic [2:0] s, input logic cs, input logic [3:0] o,
                      input logic v, input logic b);
      vec_t t;
      t.req = r; t.inp = d; t.gnt = g; t.sel = s; t.chk_sel = cs;
      t.out = o; t.ov = v; t.busy = b;
      vecs.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] PAT = 32'hFEDCBA98;  // inp[i] = 8+i

   initial begin
      rst_n = 1'b0;
      req   = 8'd0;
      inp   = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset gnt", gnt0, 0);
      chk("reset sel", sel0, 0);
      chk("reset out", out0, 0);
      chk("reset out_valid", ov0, 0);
      chk("reset busy", busy0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single requester 3: one arbitration edge, then A,B,C streamed.
      add(8'h08, 32'h0000A000, 8'h08, 3'd3, 1, 4'h0, 0, 1);
      add(8'h08, 32'h0000A000, 8'h08, 3'd3, 1, 4'hA, 1, 1);
      add(8'h08, 32'h0000B000, 8'h08, 3'd3, 1, 4'hB, 1, 1);
      add(8'h08, 32'h0000C000, 8'h08, 3'd3, 1, 4'hC, 1, 1);
      add(8'h00, 32'h0000D000, 8'h00, 3'd0, 0, 4'hC, 0, 0);
      add(8'h00, PAT,          8'h00, 3'd0, 0, 4'hC, 0, 0);
      // Hold limit 4 with req 2 and 5; ptr=4 so 5 wins first.
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hC, 0, 1);
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hD, 1, 1);
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hD, 1, 1);
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hD, 1, 1);
      add(8'h24, PAT, 8'h04, 3'd2, 1, 4'hD, 1, 1);
      add(8'h24, PAT, 8'h04, 3'd2, 1, 4'hA, 1, 1);
      add(8'h24, PAT, 8'h04, 3'd2, 1, 4'hA, 1, 1);
      add(8'h24, PAT, 8'h04, 3'd2, 1, 4'hA, 1, 1);
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hA, 1, 1);
      add(8'h24, PAT, 8'h20, 3'd5, 1, 4'hD, 1, 1);
      add(8'h00, PAT, 8'h00, 3'd0, 0, 4'hD, 0, 0);
      // Wrap priority: grant 6 leaves ptr=7, then 7 beats 0, then 6 again.
      add(8'h40, PAT, 8'h40, 3'd6, 1, 4'hD, 0, 1);
      add(8'h81, PAT, 8'h80, 3'd7, 1, 4'hD, 0, 1);
      add(8'h81, PAT, 8'h80, 3'd7, 1, 4'hF, 1, 1);
      add(8'h40, PAT, 8'h40, 3'd6, 1, 4'hF, 0, 1);
      add(8'h00, PAT, 8'h00, 3'd0, 0, 4'hF, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req;
         inp = vecs[i].inp;
         step();
         chk($sformatf("row%0d gnt", i), gnt0, vecs[i].gnt);
         if (vecs[i].chk_sel) chk($sformatf("row%0d sel", i), sel0, vecs[i].sel);
         chk($sformatf("row%0d out", i), out0, vecs[i].out);
         chk($sformatf("row%0d out_valid", i), ov0, vecs[i].ov);
         chk($sformatf("row%0d busy", i), busy0, vecs[i].busy);
      end

      // Uncontended hold: owner 0 keeps the grant past MAX_HOLD.
      req = 8'h01;
      inp = PAT;
      step();
      chk("uncont first gnt", gnt0, 8'h01);
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("uncont%0d gnt", k), gnt0, 8'h01);
         chk($sformatf("uncont%0d out_valid", k), ov0, 1);
         chk($sformatf("uncont%0d out", k), out0, 4'h8);
      end
      // Drop 0 and raise 6 together: direct handover, no bubble.
      req = 8'h40;
      step();
      chk("handover gnt", gnt0, 8'h40);
      chk("handover sel", sel0, 6);
      chk("handover busy", busy0, 1);
      chk("handover out_valid", ov0, 0);
      req = 8'h00;
      step();
      chk("handover idle gnt", gnt0, 8'h00);

      // Reset mid-grant: ptr=7 so requester 2 wins, one word transferred.
      req = 8'h04;
      step();
      chk("pre-reset gnt", gnt0, 8'h04);
      step();
      chk("pre-reset out", out0, 4'hA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset gnt", gnt0, 0);
      chk("async reset sel", sel0, 0);
      chk("async reset out", out0, 0);
      chk("async reset out_valid", ov0, 0);
      chk("async reset busy", busy0, 0);
      chk("async reset gnt dut1", gnt1, 0);
      @(negedge clk);
      req   = 8'h90;
      rst_n = 1'b1;
      step();
      chk("post-reset gnt", gnt0, 8'h10);
      chk("post-reset sel", sel0, 4);

      // Full round-robin on the MAX_HOLD=1 instance.
      req = 8'h00;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req = 8'hFF;
      inp = PAT;
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("rr%0d gnt", k), gnt1, 8'(1) << (k % 8));
         chk($sformatf("rr%0d sel", k), sel1, k % 8);
         chk($sformatf("rr%0d busy", k), busy1, 1);
         if (k >= 1) begin
            chk($sformatf("rr%0d out_valid", k), ov1, 1);
            chk($sformatf("rr%0d out", k), out1, 8 + ((k - 1) % 8));
         end
      end
      req = 8'h00;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
